// File: rtl/bh_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bh_run_ctrl
//  Purpose  : Program loader and run controller for a small core. Accepts a
//             stream of instruction beats into program memory, then gates the
//             core clock enable during a run until the core PC reaches the end
//             of the loaded program or a cycle limit expires. Single-step
//             execution is supported.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1             rising-edge clock
//    reset_n      in   1             asynchronous active-low reset
//    load_valid   in   1             load beat offered
//    load_data    in   INSTR_W       instruction for the current beat
//    load_last    in   1             current beat is the final instruction
//    load_ready   out  1             block accepts a load beat
//    start        in   1             begin run (pulse, honoured in READY only)
//    clear        in   1             abandon program, return to IDLE (pulse)
//    step_mode    in   1             1 = single-step execution
//    step         in   1             one-cycle step request in step mode
//    core_pc      in   PRG_ADDR_W+1  core program counter, zero-extended
//    core_run     out  1             core clock enable
//    prg_we       out  1             program-memory write enable
//    prg_waddr    out  PRG_ADDR_W    program-memory write address
//    prg_wdata    out  INSTR_W       program-memory write data
//    prg_len      out  PRG_ADDR_W+1  number of loaded instructions
//    cycle_count  out  CYC_W         enabled core cycles in this run
//    done         out  1             run has ended
//    timeout      out  1             run ended by the cycle limit
//    overflow     out  1             load was truncated at memory capacity
// ============================================================================
module bh_run_ctrl #(
  parameter int PRG_ADDR_W     = 8,
  parameter int INSTR_W        = 3,
  parameter int CYC_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_valid,
  input  logic [INSTR_W-1:0]    load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic [PRG_ADDR_W:0]   core_pc,
  output logic                  core_run,
  output logic                  prg_we,
  output logic [PRG_ADDR_W-1:0] prg_waddr,
  output logic [INSTR_W-1:0]    prg_wdata,
  output logic [PRG_ADDR_W:0]   prg_len,
  output logic [CYC_W-1:0]      cycle_count,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow
);

  localparam int                LEN_W     = PRG_ADDR_W + 1;
  localparam logic [CYC_W-1:0]  C_TIMEOUT = CYC_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                  state_q,    state_d;
  logic [PRG_ADDR_W-1:0]   ptr_q,      ptr_d;
  logic [LEN_W-1:0]        len_q,      len_d;
  logic [CYC_W-1:0]        cyc_q,      cyc_d;
  logic                    done_q,     done_d;
  logic                    timeout_q,  timeout_d;
  logic                    overflow_q, overflow_d;

  logic accept;
  logic ptr_full;
  logic pc_end;
  logic at_limit;
  logic run_en;

  // A beat is taken only outside of reset and never alongside clear, so a
  // clear cycle cannot leave a stray write in program memory.
  assign accept   = load_valid & load_ready & ~clear & reset_n;
  assign ptr_full = (ptr_q == {PRG_ADDR_W{1'b1}});
  assign pc_end   = (core_pc == len_q);
  assign at_limit = (cyc_q == C_TIMEOUT);
  // Step is only meaningful in step mode; otherwise the core runs freely.
  assign run_en   = ~step_mode | step;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cyc_d      = cyc_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    load_ready = 1'b0;
    prg_we     = 1'b0;
    prg_wdata  = '0;
    core_run   = 1'b0;

    case (state_q)
      S_IDLE, S_LOAD: begin
        load_ready = 1'b1;
        if (accept) begin
          prg_we    = 1'b1;
          prg_wdata = load_data;
          ptr_d     = ptr_q + 1'b1;
          // The final memory slot closes the load even without load_last;
          // the missing terminator is flagged as a truncation.
          if (load_last || ptr_full) begin
            len_d      = LEN_W'(ptr_q) + LEN_W'(1);
            overflow_d = ~load_last;
            state_d    = S_READY;
          end else begin
            state_d    = S_LOAD;
          end
        end
      end

      S_READY: begin
        if (start) begin
          cyc_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Reaching the program end takes priority over the cycle limit.
        if (pc_end) begin
          done_d    = 1'b1;
          timeout_d = 1'b0;
          state_d   = S_HALT;
        end else if (at_limit) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          core_run = run_en;
          // Saturate rather than wrap should the limit exceed the counter.
          if (run_en && (cyc_q != {CYC_W{1'b1}})) begin
            cyc_d = cyc_q + 1'b1;
          end
        end
      end

      S_HALT: begin
        // Results are held until clear.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clear) begin
      state_d    = S_IDLE;
      ptr_d      = '0;
      len_d      = '0;
      cyc_d      = '0;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  assign prg_waddr   = ptr_q;
  assign prg_len     = len_q;
  assign cycle_count = cyc_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire
